// File: rtl/arb_pkg.sv
// arb_pkg: shared sizing constants for the 8-way round-robin arbiter
package arb_pkg;
  localparam int ARB_N = 8;
  localparam int ARB_W = 16;
  localparam int ARB_SW = 3;
  localparam logic [ARB_SW-1:0] ARB_LAST_RST = 3'd7;
endpackage

// File: rtl/arb_8_16_if.sv
// arb_8_16_if: requester bus plus registered grant/data outputs of arb_8_16
interface arb_8_16_if import arb_pkg::*; #(parameter int W = ARB_W);
  logic [ARB_N-1:0] req;
  logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [ARB_N-1:0] gnt;
  logic s0, s1, s2;
  logic [W-1:0] y;
  logic valid;
  modport master (output req, d0, d1, d2, d3, d4, d5, d6, d7, input gnt, s0, s1, s2, y, valid);
  modport slave (input req, d0, d1, d2, d3, d4, d5, d6, d7, output gnt, s0, s1, s2, y, valid);
endinterface

// File: rtl/mux_8_16.sv
// mux_8_16: 8:1 word mux, select s0 (MSB) .. s2 (LSB)
module mux_8_16 #(parameter int W = 16) (
  input  logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7,
  input  logic         s0, s1, s2,
  output logic [W-1:0] y
);
  always_comb begin
    y = s0 ? (s1 ? (s2 ? d7 : d6) : (s2 ? d5 : d4))
           : (s1 ? (s2 ? d3 : d2) : (s2 ? d1 : d0));
  end
endmodule

// File: rtl/rr_pick.sv
// rr_pick: first asserted request at or after last+1, wrapping upward
module rr_pick import arb_pkg::*; #(parameter int N = ARB_N) (
  input  logic [N-1:0]      req,
  input  logic [ARB_SW-1:0] last,
  output logic [ARB_SW-1:0] win,
  output logic              found
);
  logic [ARB_SW-1:0] idx;
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = '0;
    // scan farthest offset first so the nearest hit overwrites
    for (int k = N - 1; k >= 0; k--) begin
      idx = last + ARB_SW'(k) + ARB_SW'(1);
      if (req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_8_16.sv
// arb_8_16: registered 8-way round-robin arbiter with data mux
// ARB_LOCK_EN: grantee keeps the grant while its req stays high
module arb_8_16 import arb_pkg::*; #(
  parameter int W = ARB_W,
  parameter int N = ARB_N
) (
  input logic       clk,
  input logic       rst,
  arb_8_16_if.slave bus
);
  logic [ARB_SW-1:0] last_q, last_d, sel_q, sel_d, win, pick;
  logic [N-1:0] gnt_q, gnt_d;
  logic [W-1:0] y_q, y_d, mux_y;
  logic found, locked, any;
`ifdef ARB_LOCK_EN
  assign locked = (|gnt_q) && bus.req[last_q];
`else
  assign locked = 1'b0;
`endif
  rr_pick #(.N(N)) u_pick (.req(bus.req), .last(last_q), .win(win), .found(found));
  mux_8_16 #(.W(W)) u_mux (
    .d0(bus.d0), .d1(bus.d1), .d2(bus.d2), .d3(bus.d3),
    .d4(bus.d4), .d5(bus.d5), .d6(bus.d6), .d7(bus.d7),
    .s0(pick[2]), .s1(pick[1]), .s2(pick[0]), .y(mux_y)
  );
  always_comb begin
    pick = locked ? last_q : win;
    any = locked | found;
    gnt_d = any ? N'(1) << pick : '0;
    last_d = any ? pick : last_q;
    sel_d = any ? pick : sel_q;
    y_d = any ? mux_y : y_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= ARB_LAST_RST;
      sel_q <= '0;
      gnt_q <= '0;
      y_q <= '0;
    end else begin
      last_q <= last_d;
      sel_q <= sel_d;
      gnt_q <= gnt_d;
      y_q <= y_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.valid = |gnt_q;
  assign bus.y = y_q;
  assign bus.s0 = sel_q[2];
  assign bus.s1 = sel_q[1];
  assign bus.s2 = sel_q[0];
endmodule

// File: tb/tb_arb_8_16.sv
// tb_arb_8_16: directed spec scenarios plus random traffic against a queue-free priority model
module tb_arb_8_16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] dv [8];
  int n_chk = 0;
  int n_pass = 0;
  int m_last = 7;
  int m_s = 0;
  logic [15:0] m_y = '0;
  logic [7:0] m_gnt = '0;
  arb_8_16_if #(.W(16)) bus ();
  arb_8_16 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.d0 = dv[0];
  assign bus.d1 = dv[1];
  assign bus.d2 = dv[2];
  assign bus.d3 = dv[3];
  assign bus.d4 = dv[4];
  assign bus.d5 = dv[5];
  assign bus.d6 = dv[6];
  assign bus.d7 = dv[7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  task automatic chk_all();
    chk("gnt", 32'(bus.gnt), 32'(m_gnt));
    chk("valid", 32'(bus.valid), 32'(m_gnt != 0));
    chk("y", 32'(bus.y), 32'(m_y));
    chk("s", 32'({bus.s0, bus.s1, bus.s2}), m_s);
    chk("onehot", 32'($onehot0(bus.gnt)), 1);
  endtask

  // called at a negedge: apply inputs, predict, check after the edge, return at next negedge
  task automatic cyc(input logic [7:0] r);
    int w;
    w = -1;
    bus.req = r;
`ifdef ARB_LOCK_EN
    if (m_gnt != 0 && r[m_last]) w = m_last;
`endif
    if (w < 0)
      for (int i = 1; i <= 8; i++)
        if (r[(m_last + i) % 8]) begin
          w = (m_last + i) % 8;
          break;
        end
    if (w >= 0) begin
      m_gnt = 8'(1) << w;
      m_last = w;
      m_s = w;
      m_y = dv[w];
    end else m_gnt = '0;
    @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
  endtask

  // asserts rst between edges with the given req, checks async clear, releases at a negedge
  task automatic do_reset(input logic [7:0] r);
    #2;
    rst = 1'b1;
    bus.req = r;
    m_last = 7;
    m_s = 0;
    m_y = '0;
    m_gnt = '0;
    #1;
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    dv = '{16'd13, 16'd18, 16'd24, 16'd33, 16'd55, 16'd66, 16'd77, 16'd88};
    bus.req = '0;
    @(negedge clk);
    do_reset(8'hFF);
    cyc(8'hFF);
    chk("first_y", 32'(bus.y), 13);
    for (int i = 0; i < 8; i++) cyc(8'hFF);
`ifndef ARB_LOCK_EN
    chk("wrap_y", 32'(bus.y), 13);
`endif
    do_reset(8'h00);
    for (int i = 0; i < 4; i++) cyc(8'b1000_0010);
    do_reset(8'h00);
    cyc(8'h08);
    chk("idle_pre_y", 32'(bus.y), 33);
    cyc(8'h00);
    chk("idle_y_hold", 32'(bus.y), 33);
    cyc(8'h01);
    do_reset(8'h00);
    for (int i = 0; i < 3; i++) cyc(8'h0C);
    cyc(8'h08);
    cyc(8'h08);
    cyc(8'h20);
    cyc(8'h20);
    do_reset(8'h20);
    cyc(8'h20);
    chk("post_rst_s", 32'({bus.s0, bus.s1, bus.s2}), 5);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) dv[i] = 16'($urandom);
      r = 8'($urandom);
      if ($urandom_range(3) == 0) r = r & 8'($urandom);
      if ($urandom_range(7) == 0) r = '0;
      if ($urandom_range(59) == 0) do_reset(r);
      else cyc(r);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/arb_8_16.md
ARB_8_16 -- requirements
Module: arb_8_16

Interface
- REQ-001 SHALL have parameter W, default 16, data width of each requester input and of y.
- REQ-002 SHALL have parameter N, default 8, number of requesters (fixed at 8; the select is 3 bits).
- REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port req, input, 8, per-requester request; bit i belongs to requester i.
- REQ-006 SHALL have ports d0..d7, input, W each, requester data words.
- REQ-007 SHALL have port gnt, output, 8, registered one-hot grant (all-zero when idle).
- REQ-008 SHALL have ports s0, s1, s2, output, 1 each, registered select of the granted index (s0 = MSB, s2 = LSB).
- REQ-009 SHALL have port y, output, W, registered data of the granted requester.
- REQ-010 SHALL have port valid, output, 1, high when y/gnt hold a live grant.

Function
- REQ-011 SHALL sample req on each rising clk edge and present gnt, {s0,s1,s2}, y and valid one cycle later (latency 1, registered outputs, no combinational path from req/d* to outputs).
- REQ-012 SHALL arbitrate round-robin: the search starts at index (last+1) mod 8 and rises, wrapping 7->0; the first asserted req wins.
- REQ-013 SHALL update last to the winning index on every grant; last SHALL hold when req == 0.
- REQ-014 SHALL, when req == 0, drive gnt = 0, valid = 0, and hold y and {s0,s1,s2} at their previous values.
- REQ-015 SHALL keep gnt one-hot or zero at all times; valid SHALL equal |gnt.
- REQ-016 SHALL set y to the d-input selected by the new grant index, sampled in the same cycle as req.
- REQ-017 SHALL, with a single active requester, re-grant it every cycle (no idle bubble).
- REQ-018 SHALL, when all 8 requesters are active continuously, grant each exactly once in every 8 consecutive cycles.
- REQ-019 SHALL treat a requester that drops req as ineligible in the same sample; no grant to a deasserted requester.

Reset
- REQ-020 SHALL, while rst = 1, force gnt = 0, valid = 0, y = 0, {s0,s1,s2} = 000, and last = 7, independent of clk.
- REQ-021 SHALL, on reset mid-grant, abort the grant immediately; the first sample after rst falls treats requester 0 as highest priority.

Configuration
- REQ-022 SHALL support macro ARB_LOCK_EN.
- REQ-023 With ARB_LOCK_EN defined: the current grantee SHALL keep the grant as long as its req stays high (burst lock); the rotation per REQ-012 resumes on the first cycle its req is low.
- REQ-024 Without ARB_LOCK_EN: the rotation per REQ-012 SHALL apply every cycle, so a continuously requesting grantee yields to any other active requester.

Structure
- REQ-025 SHALL place N, W, the select width (3) and the reset value of last (7) in shared package arb_pkg.
- REQ-026 SHALL implement the data path by instantiating the existing mux_8_16 (select s0,s1,s2) driven by the next-grant index, and register its output into y.
- REQ-027 SHALL implement the rotate-and-priority search as sub-module rr_pick (combinational: req, last -> win index, found).

Verification
- REQ-028 Reset: rst=1 with req=8'hFF -> gnt=0, valid=0, y=0, s=000; after rst falls, the first grant is to requester 0 with y=d0.
- REQ-029 Full rotation: d0..d7 = 13,18,24,33,55,66,77,88, req=8'hFF held 8 cycles (lock off) -> y sequence 13,18,24,33,55,66,77,88, s counts 000..111, then wraps to 13.
- REQ-030 Sparse: req=8'b1000_0010, last=7 -> grant 1 (y=18), then 7 (y=88), then 1; requesters 0 and 2..6 are never granted.
- REQ-031 Idle: req drops to 0 after granting 3 (y=33) -> valid=0, gnt=0, y stays 33, s stays 011; next req=8'h01 -> grant 0.
- REQ-032 Lock (ARB_LOCK_EN): req=8'h0C held -> grant 2 (y=24) repeated while req[2]=1; clearing req[2] -> next grant 3 (y=33). Without the macro -> alternates 2,3,2,3.
- REQ-033 Async reset mid-burst: assert rst between clk edges during a grant to 5 -> outputs clear before the next edge; the post-reset grant with req=8'h20 goes to 5 via a fresh search from 0.
